// File: rtl/fwu_pkg.sv
// Shared types and constants for the firmware-update response arbiter.
package fwu_pkg;

  localparam int unsigned FWU_MAX_REQ = 8;
  localparam int unsigned FWU_ID_W    = 3;

  typedef enum logic [1:0] {
    ST_ARB,
    ST_HDR,
    ST_PAY,
    ST_PAD
  } fwu_st_e;

  // Requester index following id, wrapping at n.
  function automatic logic [FWU_ID_W-1:0] fwu_next_id(input logic [FWU_ID_W-1:0] id,
                                                      input int unsigned n);
    if (32'(id) == n - 1) return '0;
    return id + FWU_ID_W'(1);
  endfunction

endpackage

// File: rtl/fwu_rsp_arb_if.sv
// Requester-side and transmitter-side signals of the response arbiter.
interface fwu_rsp_arb_if #(
  parameter int unsigned N_REQ = 2
);
  import fwu_pkg::*;

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ-1:0][7:0]   req_type;
  logic [N_REQ-1:0][15:0]  req_seq;
  logic [N_REQ-1:0][15:0]  req_len;
  logic [N_REQ-1:0][7:0]   req_data;
  logic [N_REQ-1:0]        req_data_valid;
  logic [N_REQ-1:0]        req_end;
  logic [N_REQ-1:0]        req_data_ready;

  logic                    tx_rsp_valid;
  logic [7:0]              tx_rsp_type;
  logic [15:0]             tx_rsp_seq;
  logic [15:0]             tx_rsp_len;
  logic [7:0]              tx_rsp_data;
  logic                    tx_rsp_data_valid;
  logic                    tx_rsp_end;
  logic                    tx_rsp_ready;
  logic                    tx_rsp_data_ready;

  logic [FWU_ID_W-1:0]     grant_id;
  logic                    busy;
  logic                    err_timeout;
  logic                    err_early_end;

  modport master (
    input  req_valid, req_type, req_seq, req_len, req_data, req_data_valid, req_end,
    input  tx_rsp_ready, tx_rsp_data_ready,
    output req_ready, req_data_ready,
    output tx_rsp_valid, tx_rsp_type, tx_rsp_seq, tx_rsp_len,
    output tx_rsp_data, tx_rsp_data_valid, tx_rsp_end,
    output grant_id, busy, err_timeout, err_early_end
  );

  modport slave (
    output req_valid, req_type, req_seq, req_len, req_data, req_data_valid, req_end,
    output tx_rsp_ready, tx_rsp_data_ready,
    input  req_ready, req_data_ready,
    input  tx_rsp_valid, tx_rsp_type, tx_rsp_seq, tx_rsp_len,
    input  tx_rsp_data, tx_rsp_data_valid, tx_rsp_end,
    input  grant_id, busy, err_timeout, err_early_end
  );

endinterface

// File: rtl/fwu_rr_pick.sv
// Combinational round-robin search: first set request at or above ptr, wrapping.
module fwu_rr_pick
  import fwu_pkg::*;
#(
  parameter int unsigned N_REQ = 2
) (
  input  logic [N_REQ-1:0]    req,
  input  logic [FWU_ID_W-1:0] ptr,
  output logic [FWU_ID_W-1:0] idx,
  output logic                any
);

  logic [FWU_MAX_REQ-1:0] req_x;
  logic [FWU_ID_W:0]      sum;
  logic [FWU_ID_W-1:0]    j;
  logic                   found;

  assign req_x = FWU_MAX_REQ'(req);
  assign any   = |req;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    sum   = '0;
    j     = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      sum = {1'b0, ptr} + (FWU_ID_W + 1)'(k);
      if (sum >= (FWU_ID_W + 1)'(N_REQ)) sum = sum - (FWU_ID_W + 1)'(N_REQ);
      j = sum[FWU_ID_W-1:0];
      if (!found && req_x[j]) begin
        found = 1'b1;
        idx   = j;
      end
    end
  end

endmodule

// File: rtl/fwu_rsp_arb.sv
// Round-robin arbiter granting one requester a whole response frame (header then payload).
module fwu_rsp_arb
  import fwu_pkg::*;
#(
  parameter int unsigned N_REQ       = 2,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input logic          clk,
  input logic          rst_n,
  fwu_rsp_arb_if.master bus
);

  localparam int unsigned SEL_W = $clog2(N_REQ);

  fwu_st_e             st_q, st_d;
  logic [FWU_ID_W-1:0] grant_q, grant_d, rr_q, rr_d, pick_idx;
  logic                pick_any;
  logic [15:0]         byte_q, byte_d, len_q, len_d, byte_inc;
  logic [31:0]         stall_q, stall_d;
  logic [SEL_W-1:0]    gsel;
  logic                last_byte, pay_hs, stall_hit;

  fwu_rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req (bus.req_valid),
    .ptr (rr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign gsel      = grant_q[SEL_W-1:0];
  assign byte_inc  = byte_q + 16'd1;
  assign last_byte = (byte_inc == len_q);
  assign pay_hs    = bus.req_data_valid[gsel] & bus.tx_rsp_data_ready;
  assign stall_hit = (TIMEOUT_CYC != 0) && (stall_q == 32'(TIMEOUT_CYC - 1));

  assign bus.tx_rsp_type = bus.req_type[gsel];
  assign bus.tx_rsp_seq  = bus.req_seq[gsel];
  assign bus.tx_rsp_len  = bus.req_len[gsel];
  assign bus.grant_id    = grant_q;
  assign bus.busy        = (st_q != ST_ARB);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= ST_ARB;
      grant_q <= '0;
      rr_q    <= '0;
      byte_q  <= '0;
      len_q   <= '0;
      stall_q <= '0;
    end else begin
      st_q    <= st_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      byte_q  <= byte_d;
      len_q   <= len_d;
      stall_q <= stall_d;
    end
  end

  always_comb begin
    st_d                  = st_q;
    grant_d               = grant_q;
    rr_d                  = rr_q;
    byte_d                = byte_q;
    len_d                 = len_q;
    stall_d               = stall_q;
    bus.req_ready         = '0;
    bus.req_data_ready    = '0;
    bus.tx_rsp_valid      = 1'b0;
    bus.tx_rsp_data_valid = 1'b0;
    bus.tx_rsp_data       = bus.req_data[gsel];
    bus.tx_rsp_end        = bus.req_end[gsel];
    bus.err_timeout       = 1'b0;
    bus.err_early_end     = 1'b0;
    unique case (st_q)
      ST_ARB: begin
        if (pick_any) begin
          grant_d = pick_idx;
          st_d    = ST_HDR;
        end
      end
      ST_HDR: begin
        bus.tx_rsp_valid    = 1'b1;
        bus.req_ready[gsel] = bus.tx_rsp_ready;
        if (bus.tx_rsp_ready) begin
          if (bus.req_len[gsel] == 16'd0) begin
            st_d = ST_ARB;
            rr_d = fwu_next_id(grant_q, N_REQ);
          end else begin
            // Length is latched so the owner may retire its header fields.
            st_d    = ST_PAY;
            len_d   = bus.req_len[gsel];
            byte_d  = '0;
            stall_d = '0;
          end
        end
      end
      ST_PAY: begin
        bus.tx_rsp_data_valid    = bus.req_data_valid[gsel];
        bus.req_data_ready[gsel] = bus.tx_rsp_data_ready;
        if (pay_hs) begin
          byte_d            = byte_inc;
          stall_d           = '0;
          bus.err_early_end = bus.req_end[gsel] && (byte_inc < len_q);
          if (last_byte) begin
            st_d = ST_ARB;
            rr_d = fwu_next_id(grant_q, N_REQ);
          end
        end else if (stall_hit) begin
          bus.err_timeout = 1'b1;
          st_d            = ST_PAD;
        end else if (stall_q != '1) begin
          stall_d = stall_q + 32'd1;
        end
      end
      ST_PAD: begin
        bus.tx_rsp_data       = 8'h00;
        bus.tx_rsp_data_valid = 1'b1;
        bus.tx_rsp_end        = last_byte;
        if (bus.tx_rsp_data_ready) begin
          byte_d = byte_inc;
          if (last_byte) begin
            st_d = ST_ARB;
            rr_d = fwu_next_id(grant_q, N_REQ);
          end
        end
      end
      default: st_d = ST_ARB;
    endcase
  end

endmodule

// File: tb/tb_fwu_rsp_arb.sv
// Scoreboard bench for fwu_rsp_arb: requester models feed frames, observed tx events are compared.
module tb_fwu_rsp_arb;

  localparam int N = 2;

  typedef struct packed {
    logic        kind;  // 0 header, 1 data beat
    logic [2:0]  id;
    logic [7:0]  b;
    logic [15:0] seq;
    logic [15:0] len;
    logic        fin;
  } ev_t;

  logic clk;
  logic rst_n;

  fwu_rsp_arb_if #(.N_REQ(N)) bus ();

  fwu_rsp_arb #(
    .N_REQ       (N),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ev_t  exp_q[$];
  ev_t  obs_q[$];
  bit   care_q[$];
  int   n_checks, n_fail;
  int   cnt_to, cnt_ee;
  bit   s_busy, s_txv;
  bit   watch_on, watch_bad, alt_rdy;

  bit          hv[N];
  bit          keep[N];
  logic [7:0]  htype[N];
  logic [15:0] hseq[N];
  logic [15:0] hlen[N];
  logic [7:0]  pay[N][16];
  bit          pfin[N][16];
  int          nbytes[N];
  int          pidx[N];

  function automatic ev_t mk(bit kind, int id, logic [7:0] b, logic [15:0] seq,
                             logic [15:0] len, bit fin);
    ev_t e;
    e.kind = kind;
    e.id   = 3'(id);
    e.b    = b;
    e.seq  = seq;
    e.len  = len;
    e.fin  = fin;
    return e;
  endfunction

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i]      = hv[i];
      bus.req_type[i]       = htype[i];
      bus.req_seq[i]        = hseq[i];
      bus.req_len[i]        = hlen[i];
      bus.req_data_valid[i] = (pidx[i] < nbytes[i]);
      bus.req_data[i]       = pay[i][pidx[i] % 16];
      bus.req_end[i]        = pfin[i][pidx[i] % 16];
    end
  endtask

  task automatic load(int i, logic [7:0] t, logic [15:0] s, logic [15:0] len);
    hv[i]     = 1'b1;
    htype[i]  = t;
    hseq[i]   = s;
    hlen[i]   = len;
    nbytes[i] = 0;
    pidx[i]   = 0;
    exp_q.push_back(mk(1'b0, i, t, s, len, 1'b0));
    care_q.push_back(1'b1);
    drive_inputs();
  endtask

  task automatic add_byte(int i, logic [7:0] d, bit fin);
    pay[i][nbytes[i]]  = d;
    pfin[i][nbytes[i]] = fin;
    nbytes[i]++;
    exp_q.push_back(mk(1'b1, i, d, 16'h0, 16'h0, fin));
    care_q.push_back(1'b1);
    drive_inputs();
  endtask

  task automatic exp_pad(int i);
    exp_q.push_back(mk(1'b1, i, 8'h00, 16'h0, 16'h0, 1'b0));
    care_q.push_back(1'b0);
  endtask

  // Sample mid-cycle, then apply requester reactions just after the rising edge.
  task automatic step();
    logic [N-1:0] hs_h, hs_d;
    @(negedge clk);
    s_busy = bus.busy;
    s_txv  = bus.tx_rsp_valid;
    if (bus.err_timeout) cnt_to++;
    if (bus.err_early_end) cnt_ee++;
    if (bus.tx_rsp_valid && bus.tx_rsp_ready)
      obs_q.push_back(mk(1'b0, int'(bus.grant_id), bus.tx_rsp_type, bus.tx_rsp_seq,
                         bus.tx_rsp_len, 1'b0));
    if (bus.tx_rsp_data_valid && bus.tx_rsp_data_ready)
      obs_q.push_back(mk(1'b1, int'(bus.grant_id), bus.tx_rsp_data, 16'h0, 16'h0,
                         bus.tx_rsp_end));
    hs_h = bus.req_valid & bus.req_ready;
    hs_d = bus.req_data_valid & bus.req_data_ready;
    if (watch_on && (bus.req_ready[0] || bus.req_data_ready[0])) watch_bad = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (hs_h[i] && !keep[i]) hv[i] = 1'b0;
      if (hs_d[i]) pidx[i]++;
    end
    if (alt_rdy) begin
      bus.tx_rsp_ready      = ~bus.tx_rsp_ready;
      bus.tx_rsp_data_ready = ~bus.tx_rsp_data_ready;
    end
    drive_inputs();
  endtask

  task automatic run_until(int nev, int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      step();
      if (obs_q.size() >= nev && !s_busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      hv[i]     = 1'b0;
      keep[i]   = 1'b0;
      htype[i]  = '0;
      hseq[i]   = '0;
      hlen[i]   = '0;
      nbytes[i] = 0;
      pidx[i]   = 0;
      for (int k = 0; k < 16; k++) begin
        pay[i][k]  = '0;
        pfin[i][k] = 1'b0;
      end
    end
    alt_rdy   = 1'b0;
    watch_on  = 1'b0;
    watch_bad = 1'b0;
    bus.tx_rsp_ready      = 1'b1;
    bus.tx_rsp_data_ready = 1'b1;
    drive_inputs();
    exp_q.delete();
    obs_q.delete();
    care_q.delete();
    cnt_to = 0;
    cnt_ee = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.busy, bus.err_timeout, bus.err_early_end, bus.grant_id} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_status: got %b, expected 000000",
               {bus.busy, bus.err_timeout, bus.err_early_end, bus.grant_id});
    end
    n_checks++;
    if ({bus.tx_rsp_valid, bus.tx_rsp_data_valid, bus.req_ready, bus.req_data_ready} !== '0) begin
      n_fail++;
      $display("FAIL reset_hs: got %b, expected all zero",
               {bus.tx_rsp_valid, bus.tx_rsp_data_valid, bus.req_ready, bus.req_data_ready});
    end
    do_reset();
    step();
    n_checks++;
    if ({s_busy, s_txv, bus.req_ready, bus.req_data_ready} !== '0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got busy=%b txv=%b rdy=%b drdy=%b, expected zeros",
               s_busy, s_txv, bus.req_ready, bus.req_data_ready);
    end
  endtask

  task automatic test_basic();
    ev_t e, o;
    bit  c;
    do_reset();
    load(0, 8'hA0, 16'h0101, 16'd3);
    add_byte(0, 8'h11, 1'b0);
    add_byte(0, 8'h22, 1'b0);
    add_byte(0, 8'h33, 1'b1);
    step();
    n_checks++;
    if (s_txv !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_lat0: tx_rsp_valid got %b, expected 0", s_txv);
    end
    step();
    n_checks++;
    if (s_txv !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_lat1: tx_rsp_valid got %b, expected 1", s_txv);
    end
    for (int k = 0; k < 20 && obs_q.size() < 4; k++) step();
    step();
    n_checks++;
    if (s_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_busy: busy after 3rd beat got %b, expected 0", s_busy);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      c = care_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL basic_sb: got none, expected %h", e);
      end else begin
        o = obs_q.pop_front();
        if (!c) o.fin = e.fin;
        if (o !== e) begin
          n_fail++;
          $display("FAIL basic_sb: got %h, expected %h", o, e);
        end
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL basic_extra: got %0d extra events, expected 0", obs_q.size());
    end
  endtask

  task automatic test_round_robin();
    ev_t e, o;
    bit  c;
    do_reset();
    keep[0] = 1'b1;
    keep[1] = 1'b1;
    load(0, 8'h10, 16'h1000, 16'd0);
    load(1, 8'h21, 16'h2001, 16'd0);
    exp_q.push_back(mk(1'b0, 0, 8'h10, 16'h1000, 16'd0, 1'b0));
    care_q.push_back(1'b1);
    exp_q.push_back(mk(1'b0, 1, 8'h21, 16'h2001, 16'd0, 1'b0));
    care_q.push_back(1'b1);
    for (int k = 0; k < 40 && obs_q.size() < 4; k++) step();
    hv[0] = 1'b0;
    hv[1] = 1'b0;
    drive_inputs();
    repeat (3) step();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      c = care_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL rr_sb: got none, expected %h", e);
      end else begin
        o = obs_q.pop_front();
        if (!c) o.fin = e.fin;
        if (o !== e) begin
          n_fail++;
          $display("FAIL rr_sb: got %h, expected %h", o, e);
        end
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL rr_extra: got %0d extra events, expected 0", obs_q.size());
    end
  endtask

  task automatic test_grant_hold();
    ev_t e, o;
    bit  c, ok;
    do_reset();
    alt_rdy = 1'b1;
    load(1, 8'h31, 16'h3100, 16'd4);
    add_byte(1, 8'hB1, 1'b0);
    add_byte(1, 8'hB2, 1'b0);
    add_byte(1, 8'hB3, 1'b0);
    add_byte(1, 8'hB4, 1'b1);
    watch_on = 1'b1;
    for (int k = 0; k < 20 && obs_q.size() < 2; k++) step();
    load(0, 8'h0C, 16'h0C00, 16'd2);
    add_byte(0, 8'hC1, 1'b0);
    add_byte(0, 8'hC2, 1'b1);
    for (int k = 0; k < 30 && obs_q.size() < 5; k++) step();
    watch_on = 1'b0;
    run_until(8, 40, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL hold_done: frames got %0d events, expected 8 then idle", obs_q.size());
    end
    n_checks++;
    if (watch_bad !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_ready0: req0 ready seen got %b, expected 0", watch_bad);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      c = care_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL hold_sb: got none, expected %h", e);
      end else begin
        o = obs_q.pop_front();
        if (!c) o.fin = e.fin;
        if (o !== e) begin
          n_fail++;
          $display("FAIL hold_sb: got %h, expected %h", o, e);
        end
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL hold_extra: got %0d extra events, expected 0", obs_q.size());
    end
  endtask

  task automatic test_timeout();
    ev_t e, o;
    bit  c, ok;
    do_reset();
    load(1, 8'h55, 16'h5500, 16'd5);
    add_byte(1, 8'hD1, 1'b0);
    add_byte(1, 8'hD2, 1'b0);
    repeat (3) exp_pad(1);
    run_until(6, 60, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL to_done: got %0d events, expected 6 then idle", obs_q.size());
    end
    n_checks++;
    if (cnt_to != 1 || cnt_ee != 0) begin
      n_fail++;
      $display("FAIL to_pulses: got timeout=%0d early=%0d, expected 1 and 0", cnt_to, cnt_ee);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      c = care_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL to_sb: got none, expected %h", e);
      end else begin
        o = obs_q.pop_front();
        if (!c) o.fin = e.fin;
        if (o !== e) begin
          n_fail++;
          $display("FAIL to_sb: got %h, expected %h", o, e);
        end
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL to_extra: got %0d extra events, expected 0", obs_q.size());
    end
  endtask

  task automatic test_early_end();
    ev_t e, o;
    bit  c, ok;
    do_reset();
    load(0, 8'h44, 16'h4400, 16'd4);
    add_byte(0, 8'hE1, 1'b0);
    add_byte(0, 8'hE2, 1'b1);
    add_byte(0, 8'hE3, 1'b0);
    add_byte(0, 8'hE4, 1'b0);
    run_until(5, 40, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL ee_done: got %0d events, expected 5 then idle", obs_q.size());
    end
    n_checks++;
    if (cnt_ee != 1 || cnt_to != 0) begin
      n_fail++;
      $display("FAIL ee_pulses: got early=%0d timeout=%0d, expected 1 and 0", cnt_ee, cnt_to);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      c = care_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL ee_sb: got none, expected %h", e);
      end else begin
        o = obs_q.pop_front();
        if (!c) o.fin = e.fin;
        if (o !== e) begin
          n_fail++;
          $display("FAIL ee_sb: got %h, expected %h", o, e);
        end
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL ee_extra: got %0d extra events, expected 0", obs_q.size());
    end
  endtask

  task automatic test_reset_mid_frame();
    ev_t e, o;
    bit  c, ok;
    do_reset();
    load(1, 8'h66, 16'h6600, 16'd6);
    add_byte(1, 8'hF1, 1'b0);
    for (int k = 0; k < 20 && obs_q.size() < 2; k++) step();
    repeat (3) step();
    n_checks++;
    if (s_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_busy: busy before reset got %b, expected 1", s_busy);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.busy, bus.err_timeout, bus.err_early_end, bus.grant_id} !== 6'b0) begin
      n_fail++;
      $display("FAIL mid_status: got %b, expected 000000",
               {bus.busy, bus.err_timeout, bus.err_early_end, bus.grant_id});
    end
    n_checks++;
    if ({bus.tx_rsp_valid, bus.tx_rsp_data_valid, bus.req_ready, bus.req_data_ready} !== '0) begin
      n_fail++;
      $display("FAIL mid_hs: got %b, expected all zero",
               {bus.tx_rsp_valid, bus.tx_rsp_data_valid, bus.req_ready, bus.req_data_ready});
    end
    do_reset();
    load(1, 8'h77, 16'h7700, 16'd0);
    run_until(1, 20, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL mid_regrant: got %0d events, expected 1 then idle", obs_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      c = care_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL mid_sb: got none, expected %h", e);
      end else begin
        o = obs_q.pop_front();
        if (!c) o.fin = e.fin;
        if (o !== e) begin
          n_fail++;
          $display("FAIL mid_sb: got %h, expected %h", o, e);
        end
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL mid_extra: got %0d extra events, expected 0", obs_q.size());
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    test_reset();
    test_basic();
    test_round_robin();
    test_grant_hold();
    test_timeout();
    test_early_end();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time got 200000, expected completion earlier");
    $fatal(1, "bench time limit");
  end

endmodule

// File: doc/fwu_rsp_arb.md
FWU_RSP_ARB -- requirements
Module: fwu_rsp_arb

Interface
REQ-001 Parameter N_REQ, default 2: number of response requesters, range 2..8.
REQ-002 Parameter TIMEOUT_CYC, default 4096: payload stall limit in cycles; 0 disables the watchdog.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 req_valid  in  N_REQ  per-requester header valid.
REQ-006 req_ready  out  N_REQ  per-requester header accept.
REQ-007 req_type / req_seq / req_len  in  N_REQ x 8 / 16 / 16  per-requester header fields.
REQ-008 req_data, req_data_valid, req_end  in  N_REQ x 8, N_REQ, N_REQ  per-requester payload stream.
REQ-009 req_data_ready  out  N_REQ  per-requester payload accept.
REQ-010 tx_rsp_valid, tx_rsp_type, tx_rsp_seq, tx_rsp_len, tx_rsp_data, tx_rsp_data_valid, tx_rsp_end  out  1, 8, 16, 16, 8, 1, 1  to the frame transmitter.
REQ-011 tx_rsp_ready, tx_rsp_data_ready  in  1, 1  from the frame transmitter.
REQ-012 grant_id  out  3  index of the current owner; valid when busy=1.
REQ-013 busy  out  1  high outside ST_ARB.
REQ-014 err_timeout  out  1  one-cycle pulse when the watchdog fires.
REQ-015 err_early_end  out  1  one-cycle pulse when req_end is seen before the final byte.

Function
REQ-016 FSM states: ST_ARB, ST_HDR, ST_PAY, ST_PAD.
REQ-017 ST_ARB: if any req_valid is high, register the round-robin winner (search from rr_ptr upward, wrapping) into grant_id, then go to ST_HDR; otherwise stay.
REQ-018 Arbitration latency: exactly 1 cycle from req_valid to tx_rsp_valid when the block is idle.
REQ-019 ST_HDR: tx_rsp_valid=1 with the owner's header fields muxed through combinationally.
REQ-020 ST_HDR: req_ready[grant_id]=tx_rsp_ready; every other req_ready bit is 0.
REQ-021 On the header handshake, len==0 -> ST_ARB with rr_ptr=grant_id+1 mod N_REQ.
REQ-022 On the header handshake, len!=0 -> ST_PAY with byte_cnt=0 and stall_cnt=0.
REQ-023 ST_PAY: tx_rsp_data/valid/end come from the owner.
REQ-024 ST_PAY: req_data_ready[grant_id]=tx_rsp_data_ready; all other ready bits are 0.
REQ-025 Each ST_PAY data handshake increments byte_cnt (16-bit) and clears stall_cnt.
REQ-026 When byte_cnt+1==len on a handshake: go to ST_ARB and advance rr_ptr.
REQ-027 Owner req_end on a handshake with byte_cnt+1<len pulses err_early_end; the transfer continues.
REQ-028 ST_PAY with no handshake increments stall_cnt (saturating).
REQ-029 When stall_cnt reaches TIMEOUT_CYC-1 (TIMEOUT_CYC!=0): pulse err_timeout, then go to ST_PAD.
REQ-030 ST_PAD: tx_rsp_data=8'h00, tx_rsp_data_valid=1, all req_data_ready=0; count handshakes to len, then ST_ARB with rr_ptr advanced.
REQ-031 The owner's req_valid dropping after grant is ignored; the grant holds until the frame completes.
REQ-032 Simultaneous requests resolve by round-robin only, with no fixed priority; a requester granted last is lowest next round.
REQ-033 In ST_ARB and ST_HDR: tx_rsp_data_valid=0 and all req_data_ready=0.
REQ-034 Outside ST_HDR: tx_rsp_valid=0 and all req_ready=0.

Reset
REQ-035 rst_n low, including mid-frame, forces st=ST_ARB, rr_ptr=0, grant_id=0, byte_cnt=0, stall_cnt=0.
REQ-036 During reset: busy=0, err_timeout=0, err_early_end=0, tx_rsp_valid=0, tx_rsp_data_valid=0, all req_ready=0, all req_data_ready=0.
REQ-037 Release of rst_n is synchronized externally; the first grant occurs no earlier than the 2nd edge after release.

Structure
REQ-038 The state enum and FWU_MAX_REQ=8 live in package fwu_pkg.
REQ-039 The round-robin winner search is sub-module fwu_rr_pick (combinational: req vector, pointer -> index, any).

Verification
REQ-040 Requester 0 sends len=3 bytes 11,22,33 with tx ready always high -> tx_rsp_valid at cycle 1, three data beats, busy low after the 3rd beat.
REQ-041 Both requesters are valid continuously with len=0 -> grants alternate 0,1,0,1; no back-to-back repeat.
REQ-042 Requester 1 is granted with len=4 and requester 0 asserts req_valid mid-payload -> req_ready[0] and req_data_ready[0] stay 0 until requester 1's 4th beat.
REQ-043 TIMEOUT_CYC=16, len=5, owner stalls after 2 bytes -> err_timeout pulses once, then 3 bytes of 00 are sent, then ST_ARB.
REQ-044 len=4 with req_end on the 2nd beat -> err_early_end pulses once and beats 3 and 4 still pass.
REQ-045 rst_n asserted during ST_PAY -> all outputs 0 immediately; after release, requester 1 wins first when only it is valid.
